// File: rtl/monopulse_ratio.sv
// monopulse_ratio: multi-channel |error_k| / |reference| engine.
// The sum channel is shared by all error channels. Each channel is divided in
// turn by a radix-2 restoring divider that produces one quotient bit per cycle.
// The result is an unsigned fixed-point magnitude with FRAC_BITS fraction bits,
// plus a sign bit and a divide-by-zero flag.
//
// Handshake: o_ready is high only in IDLE, and never while i_reset is asserted.
// A start is taken on the rising edge where i_start=1 and o_ready=1. Both
// inputs are latched on that edge. A start at any other time is dropped.
// Each channel result is presented for one cycle with o_valid=1. o_done marks
// the last channel. There is no backpressure on the result side.
module monopulse_ratio #(
  parameter int DATA_SIZE  = 64,
  parameter int FRAC_BITS  = DATA_SIZE,
  parameter int N_CHANNELS = 2,
  localparam int CH_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [DATA_SIZE-1:0]            i_reference,
  input  logic [N_CHANNELS*DATA_SIZE-1:0] i_errors,
  input  logic                            i_start,
  output logic                            o_ready,
  output logic [DATA_SIZE+FRAC_BITS-1:0]  o_result,
  output logic                            o_sign,
  output logic                            o_div_zero,
  output logic [CH_W-1:0]                 o_channel,
  output logic                            o_valid,
  output logic                            o_done,
  output logic [1:0]                      state_dbg
);

  localparam int QW    = DATA_SIZE + FRAC_BITS;  // quotient / dividend width
  localparam int ITER  = QW;                     // one quotient bit per DIV cycle
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int RW    = DATA_SIZE + 1;          // remainder register width
  localparam int SW    = DATA_SIZE + 2;          // remainder after the shift-in

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DATA_SIZE-1:0]            ref_q;
  logic [N_CHANNELS*DATA_SIZE-1:0] err_q;
  logic [CH_W-1:0]                 ch_q;
  logic [DATA_SIZE-1:0]            abs_ref_q;
  logic [RW-1:0]                   rem_q;
  logic [QW-1:0]                   dvd_q;
  logic [QW-1:0]                   quo_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            sign_q;

  logic [DATA_SIZE-1:0] err_sel;
  logic [DATA_SIZE-1:0] abs_err;
  logic [DATA_SIZE-1:0] abs_ref;
  logic                 ch_sign;
  logic [SW-1:0]        rem_shift;
  logic                 rem_ge;
  logic [SW-1:0]        rem_next;
  logic [QW-1:0]        quo_next;
  logic                 last_ch;
  logic                 div_last;
  logic                 ref_zero;

  assign state_dbg = state;

  // Operand selection, magnitudes, sign, and one restoring-division step
  always_comb begin
    err_sel   = err_q[int'(ch_q)*DATA_SIZE +: DATA_SIZE];
    // Two's-complement negation maps the most negative value to 2^(DATA_SIZE-1)
    abs_err   = err_sel[DATA_SIZE-1] ? -err_sel : err_sel;
    abs_ref   = ref_q[DATA_SIZE-1] ? -ref_q : ref_q;
    ref_zero  = (abs_ref == '0);
    ch_sign   = (err_sel != '0) & (err_sel[DATA_SIZE-1] ^ ref_q[DATA_SIZE-1]);
    rem_shift = {rem_q, dvd_q[QW-1]};
    rem_ge    = (rem_shift >= SW'(abs_ref_q));
    rem_next  = rem_ge ? (rem_shift - SW'(abs_ref_q)) : rem_shift;
    quo_next  = (quo_q << 1) | QW'(rem_ge);
    last_ch   = (ch_q == CH_W'(N_CHANNELS - 1));
    div_last  = (cnt_q == CNT_W'(1));
  end

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (i_start) state_next = S_LOAD;
      S_LOAD: state_next = ref_zero ? S_OUT : S_DIV;
      S_DIV:  if (div_last) state_next = S_OUT;
      S_OUT:  state_next = last_ch ? S_IDLE : S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake and strobe outputs decoded from the state
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_done  = 1'b0;
    case (state)
      S_IDLE: o_ready = ~i_reset;
      S_OUT: begin
        o_valid = 1'b1;
        o_done  = last_ch;
      end
      default: ;
    endcase
  end

  // Datapath: input latch, divider iteration, and registered result fields
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      ref_q      <= '0;
      err_q      <= '0;
      ch_q       <= '0;
      abs_ref_q  <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      o_result   <= '0;
      o_sign     <= 1'b0;
      o_div_zero <= 1'b0;
      o_channel  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            ref_q <= i_reference;
            err_q <= i_errors;
            ch_q  <= '0;
          end
        end
        S_LOAD: begin
          abs_ref_q <= abs_ref;
          sign_q    <= ch_sign;
          rem_q     <= '0;
          dvd_q     <= QW'(abs_err) << FRAC_BITS;
          quo_q     <= '0;
          cnt_q     <= CNT_W'(ITER);
          // A zero reference skips the divider and saturates the quotient
          if (ref_zero) begin
            o_result   <= '1;
            o_sign     <= ch_sign;
            o_div_zero <= 1'b1;
            o_channel  <= ch_q;
          end
        end
        S_DIV: begin
          rem_q <= RW'(rem_next);
          dvd_q <= dvd_q << 1;
          quo_q <= quo_next;
          cnt_q <= cnt_q - CNT_W'(1);
          // The final quotient bit goes straight into the result register
          if (div_last) begin
            o_result   <= quo_next;
            o_sign     <= sign_q;
            o_div_zero <= 1'b0;
            o_channel  <= ch_q;
          end
        end
        S_OUT: begin
          if (!last_ch) ch_q <= ch_q + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_monopulse_ratio.sv
// Directed testbench for monopulse_ratio with DATA_SIZE=8, FRAC_BITS=8, N=2.
// Cycle numbering: cycle 0 is the edge that samples the start.
// Cycle n is the interval that ends at edge n.
// Outputs are sampled 1 ns after each rising edge.
module tb_monopulse_ratio;

  localparam int D = 8;
  localparam int F = 8;
  localparam int N = 2;

  logic          clk;
  logic          i_reset;
  logic [D-1:0]  i_reference;
  logic [N*D-1:0] i_errors;
  logic          i_start;
  logic          o_ready;
  logic [D+F-1:0] o_result;
  logic          o_sign;
  logic          o_div_zero;
  logic          o_channel;
  logic          o_valid;
  logic          o_done;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;

  logic [D+F-1:0] exp_q[$];

  // Captured per-transaction observations
  int             nv;
  int             done_cyc;
  int             v_cyc  [4];
  logic [D+F-1:0] v_res  [4];
  logic           v_sign [4];
  logic           v_dz   [4];
  logic           v_ch   [4];
  logic           v_done [4];
  logic           rdy_start;
  logic           rdy_after;

  monopulse_ratio #(.DATA_SIZE(D), .FRAC_BITS(F), .N_CHANNELS(N)) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_reference (i_reference),
    .i_errors    (i_errors),
    .i_start     (i_start),
    .o_ready     (o_ready),
    .o_result    (o_result),
    .o_sign      (o_sign),
    .o_div_zero  (o_div_zero),
    .o_channel   (o_channel),
    .o_valid     (o_valid),
    .o_done      (o_done),
    .state_dbg   (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver and monitor: start one transaction, record every o_valid until o_done
  task automatic run_txn(input logic [D-1:0] r, input logic [D-1:0] e0,
                         input logic [D-1:0] e1, input int budget);
    nv = 0;
    done_cyc = -1;
    rdy_after = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v_cyc[k] = -1; v_res[k] = 'x; v_sign[k] = 1'bx;
      v_dz[k] = 1'bx; v_ch[k] = 1'bx; v_done[k] = 1'bx;
    end
    i_reference = r;
    i_errors    = {e1, e0};
    i_start     = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    rdy_start = o_ready;
    for (int c = 1; c <= budget; c++) begin
      if (o_valid === 1'b1) begin
        if (nv < 4) begin
          v_cyc[nv] = c; v_res[nv] = o_result; v_sign[nv] = o_sign;
          v_dz[nv] = o_div_zero; v_ch[nv] = o_channel; v_done[nv] = o_done;
        end
        nv++;
      end
      if (o_done === 1'b1) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_cyc >= 0) begin
      @(posedge clk); #1;
      rdy_after = o_ready;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 1'b0; i_reference = '0; i_errors = '0;
    #2;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_reset got=%b exp=0", o_ready); end
    total++; if (o_valid !== 1'b0 || o_done !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", o_valid, o_done); end
    total++; if (o_result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h exp=0000", o_result); end
    total++; if ({o_sign, o_div_zero, o_channel} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {o_sign, o_div_zero, o_channel}); end
    repeat (2) @(posedge clk);
    @(negedge clk); i_reset = 1'b0; #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", o_ready); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_basic();
    logic [D+F-1:0] e;
    exp_q.push_back(16'h0180);
    exp_q.push_back(16'h0040);
    run_txn(8'd4, 8'd6, 8'd1, 100);
    total++; if (nv !== 2) begin bad++; $display("FAIL basic_count got=%0d exp=2", nv); end
    total++; if (rdy_start !== 1'b0) begin bad++; $display("FAIL basic_ready_busy got=%b exp=0", rdy_start); end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      total++; if (v_res[k] !== e) begin bad++; $display("FAIL basic_result ch%0d got=%h exp=%h", k, v_res[k], e); end
      total++; if (v_cyc[k] !== (k + 1) * 18) begin bad++; $display("FAIL basic_cycle ch%0d got=%0d exp=%0d", k, v_cyc[k], (k + 1) * 18); end
      total++; if (v_ch[k] !== 1'(k)) begin bad++; $display("FAIL basic_channel ch%0d got=%b exp=%0d", k, v_ch[k], k); end
      total++; if (v_sign[k] !== 1'b0 || v_dz[k] !== 1'b0) begin bad++; $display("FAIL basic_flags ch%0d got=%b%b exp=00", k, v_sign[k], v_dz[k]); end
      total++; if (v_done[k] !== (k == 1)) begin bad++; $display("FAIL basic_done ch%0d got=%b exp=%b", k, v_done[k], k == 1); end
    end
    total++; if (done_cyc !== 36) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=36", done_cyc); end
    total++; if (rdy_after !== 1'b1) begin bad++; $display("FAIL basic_ready_return got=%b exp=1", rdy_after); end
  endtask

  task automatic test_signs();
    run_txn(8'hFC, 8'd6, 8'hFA, 100);   // ref=-4, err0=6, err1=-6
    total++; if (nv !== 2) begin bad++; $display("FAIL signs_count got=%0d exp=2", nv); end
    total++; if (v_res[0] !== 16'h0180 || v_res[1] !== 16'h0180) begin bad++; $display("FAIL signs_result got=%h,%h exp=0180,0180", v_res[0], v_res[1]); end
    total++; if (v_sign[0] !== 1'b1) begin bad++; $display("FAIL signs_sign0 got=%b exp=1", v_sign[0]); end
    total++; if (v_sign[1] !== 1'b0) begin bad++; $display("FAIL signs_sign1 got=%b exp=0", v_sign[1]); end
  endtask

  task automatic test_extremes();
    logic [D-1:0]   t_ref [3];
    logic [D-1:0]   t_e0  [3];
    logic [D-1:0]   t_e1  [3];
    logic [D+F-1:0] t_q0  [3];
    logic [D+F-1:0] t_q1  [3];
    logic           t_s0  [3];
    logic           t_s1  [3];
    // ref=1: -128 -> 128.0 neg, 0 -> 0
    t_ref[0] = 8'h01; t_e0[0] = 8'h80; t_e1[0] = 8'h00; t_q0[0] = 16'h8000; t_q1[0] = 16'h0000; t_s0[0] = 1'b1; t_s1[0] = 1'b0;
    // ref=-128: 127/128 = 0.9921875 neg, -128/-128 = 1.0 pos
    t_ref[1] = 8'h80; t_e0[1] = 8'h7F; t_e1[1] = 8'h80; t_q0[1] = 16'h00FE; t_q1[1] = 16'h0100; t_s0[1] = 1'b1; t_s1[1] = 1'b0;
    // ref=-3: zero error keeps sign 0; -128/-3 = 42.66 -> 0x2AAA pos
    t_ref[2] = 8'hFD; t_e0[2] = 8'h00; t_e1[2] = 8'h80; t_q0[2] = 16'h0000; t_q1[2] = 16'h2AAA; t_s0[2] = 1'b0; t_s1[2] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      run_txn(t_ref[t], t_e0[t], t_e1[t], 100);
      total++; if (v_res[0] !== t_q0[t]) begin bad++; $display("FAIL extreme_result0 v%0d got=%h exp=%h", t, v_res[0], t_q0[t]); end
      total++; if (v_res[1] !== t_q1[t]) begin bad++; $display("FAIL extreme_result1 v%0d got=%h exp=%h", t, v_res[1], t_q1[t]); end
      total++; if (v_sign[0] !== t_s0[t] || v_sign[1] !== t_s1[t]) begin bad++; $display("FAIL extreme_sign v%0d got=%b%b exp=%b%b", t, v_sign[0], v_sign[1], t_s0[t], t_s1[t]); end
    end
  endtask

  task automatic test_div_zero();
    run_txn(8'h00, 8'd5, 8'hFB, 20);   // ref=0, err0=5, err1=-5
    total++; if (nv !== 2) begin bad++; $display("FAIL dz_count got=%0d exp=2", nv); end
    total++; if (v_cyc[0] !== 2 || v_cyc[1] !== 4) begin bad++; $display("FAIL dz_cycles got=%0d,%0d exp=2,4", v_cyc[0], v_cyc[1]); end
    total++; if (v_res[0] !== 16'hFFFF || v_res[1] !== 16'hFFFF) begin bad++; $display("FAIL dz_result got=%h,%h exp=ffff,ffff", v_res[0], v_res[1]); end
    total++; if (v_dz[0] !== 1'b1 || v_dz[1] !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b%b exp=11", v_dz[0], v_dz[1]); end
    total++; if (v_sign[0] !== 1'b0 || v_sign[1] !== 1'b1) begin bad++; $display("FAIL dz_sign got=%b%b exp=01", v_sign[0], v_sign[1]); end
    total++; if (done_cyc !== 4) begin bad++; $display("FAIL dz_done_cycle got=%0d exp=4", done_cyc); end
  endtask

  task automatic test_handshake();
    int             n;
    int             nd;
    int             h_cyc [4];
    logic [D+F-1:0] h_res [4];
    int             x_cyc [4];
    logic [D+F-1:0] x_res [4];
    x_cyc[0] = 18; x_cyc[1] = 36; x_cyc[2] = 55; x_cyc[3] = 73;
    x_res[0] = 16'h0180; x_res[1] = 16'h0040; x_res[2] = 16'h0300; x_res[3] = 16'h0200;
    n = 0; nd = 0;
    for (int k = 0; k < 4; k++) begin h_cyc[k] = -1; h_res[k] = 'x; end
    i_reference = 8'd4; i_errors = {8'd1, 8'd6}; i_start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 80; c++) begin
      if (c == 5) begin i_reference = 8'd1; i_errors = {8'd2, 8'd3}; end
      if (c == 40) i_start = 1'b0;
      if (o_valid === 1'b1) begin
        if (n < 4) begin h_cyc[n] = c; h_res[n] = o_result; end
        n++;
      end
      if (o_done === 1'b1) nd++;
      if (c == 37) begin total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL hs_ready_c37 got=%b exp=1", o_ready); end end
      if (c == 38) begin total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL hs_ready_c38 got=%b exp=0", o_ready); end end
      if (c == 74) begin total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL hs_ready_c74 got=%b exp=1", o_ready); end end
      @(posedge clk); #1;
    end
    total++; if (n !== 4) begin bad++; $display("FAIL hs_valid_count got=%0d exp=4", n); end
    total++; if (nd !== 2) begin bad++; $display("FAIL hs_done_count got=%0d exp=2", nd); end
    for (int k = 0; k < 4; k++) begin
      total++; if (h_cyc[k] !== x_cyc[k] || h_res[k] !== x_res[k]) begin bad++; $display("FAIL hs_result%0d got=%h@%0d exp=%h@%0d", k, h_res[k], h_cyc[k], x_res[k], x_cyc[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    i_reference = 8'd4; i_errors = {8'd1, 8'd6}; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end   // now in cycle 10
    total++; if (state_dbg !== 2'd2) begin bad++; $display("FAIL rmid_in_div got=%0d exp=2", state_dbg); end
    i_reset = 1'b1; #1;
    total++; if (o_result !== 16'h0000) begin bad++; $display("FAIL rmid_result got=%h exp=0000", o_result); end
    total++; if ({o_sign, o_div_zero, o_channel, o_valid, o_done, o_ready} !== 6'b0) begin bad++; $display("FAIL rmid_outputs got=%b exp=000000", {o_sign, o_div_zero, o_channel, o_valid, o_done, o_ready}); end
    repeat (2) @(posedge clk);
    @(negedge clk); i_reset = 1'b0; #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", o_ready); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0 || o_done !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_no_valid got=%0d exp=0", seen); end
    run_txn(8'd4, 8'd6, 8'd1, 100);
    total++; if (v_res[0] !== 16'h0180 || v_res[1] !== 16'h0040) begin bad++; $display("FAIL rmid_restart got=%h,%h exp=0180,0040", v_res[0], v_res[1]); end
    total++; if (done_cyc !== 36) begin bad++; $display("FAIL rmid_restart_done got=%0d exp=36", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_extremes();
    test_div_zero();
    test_handshake();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
